// File: rtl/decode_pkg.sv
// Shared field positions, widths and the decoded-output bundle for the decode stage.
// Latency: n/a. Backpressure: n/a.
package decode_pkg;
  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int OPW  = 6;
  localparam int NREG = 32;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS_HI  = 20;
  localparam int RS_LO  = 16;
  localparam int RT_HI  = 15;
  localparam int RT_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam int IMM_FORM_BIT = 5;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  data_in;
    logic [OPW-1:0] op_dec;
    logic [AW-1:0]  rd;
  } dec_out_t;

  // The form bit selects B's source only; the ALU sees the low five op bits.
  function automatic logic [OPW-1:0] op_decode(input logic [OP_HI-OP_LO:0] op);
    return {1'b0, op[4:0]};
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, writeback-side and execute-side signals of the decode stage.
// Latency: n/a. Backpressure: valid/ready on both the instruction and the output side.
interface decode_stage_if;
  import decode_pkg::*;

  logic [31:0]     instr;
  logic            in_valid;
  logic            in_ready;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [DW-1:0]   A;
  logic [DW-1:0]   B;
  logic [DW-1:0]   data_in;
  logic [OPW-1:0]  op_dec;
  logic [AW-1:0]   rd_out;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output instr, in_valid, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, A, B, data_in, op_dec, rd_out, out_valid
  );

  modport slave (
    input  instr, in_valid, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, A, B, data_in, op_dec, rd_out, out_valid
  );
endinterface

// File: rtl/reg_file_32x16.sv
// 32x16 register file: two asynchronous read ports, one synchronous write port, R0 hardwired to 0.
// Latency: reads combinational, writes visible after the write edge. Backpressure: none.
module reg_file_32x16
  import decode_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == REG_ZERO) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == REG_ZERO) ? '0 : mem[raddr_b];
endmodule

// File: rtl/decode_stage.sv
// Decode/operand fetch: reads rs/rt, registers A, B, op_dec, data_in and rd for execute. REGFILE_BYPASS_EN forwards wb_data on a read collision instead of stalling.
// Latency: 1 cycle from accept. Backpressure: in_ready = !reset && (!out_valid || out_ready) && !stall; output held while stalled downstream.
module decode_stage
  import decode_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  decode_stage_if.slave  io
);
  logic [OP_HI-OP_LO:0] op;
  logic [AW-1:0]        rs;
  logic [AW-1:0]        rt;
  logic [AW-1:0]        rd;
  logic [DW-1:0]        imm;
  logic [DW-1:0]        rf_a;
  logic [DW-1:0]        rf_b;
  logic [DW-1:0]        rs_val;
  logic [DW-1:0]        rt_val;
  logic                 wb_hit;
  logic                 hit_rs;
  logic                 hit_rt;
  logic                 stall;
  logic                 accept;
  logic                 out_valid_q;
  dec_out_t             out_q;

  assign op  = io.instr[OP_HI:OP_LO];
  assign rd  = io.instr[RD_HI:RD_LO];
  assign rs  = io.instr[RS_HI:RS_LO];
  assign rt  = io.instr[RT_HI:RT_LO];
  assign imm = io.instr[IMM_HI:IMM_LO];

  reg_file_32x16 u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (io.wb_en),
    .waddr   (io.wb_addr),
    .wdata   (io.wb_data),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b)
  );

  // rt is always compared because data_in reads it even in immediate form.
  assign wb_hit = io.wb_en && (io.wb_addr != REG_ZERO);
  assign hit_rs = wb_hit && (io.wb_addr == rs);
  assign hit_rt = wb_hit && (io.wb_addr == rt);

`ifdef REGFILE_BYPASS_EN
  assign rs_val = hit_rs ? io.wb_data : rf_a;
  assign rt_val = hit_rt ? io.wb_data : rf_b;
  assign stall  = 1'b0;
`else
  assign rs_val = rf_a;
  assign rt_val = rf_b;
  assign stall  = io.in_valid && (hit_rs || hit_rt);
`endif

  assign io.in_ready = !reset && (!out_valid_q || io.out_ready) && !stall;
  assign accept      = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q.a       <= rs_val;
      out_q.b       <= op[IMM_FORM_BIT] ? imm : rt_val;
      out_q.data_in <= rt_val;
      out_q.op_dec  <= op_decode(op);
      out_q.rd      <= rd;
      out_valid_q   <= 1'b1;
    end else if (io.out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign io.A         = out_q.a;
  assign io.B         = out_q.b;
  assign io.data_in   = out_q.data_in;
  assign io.op_dec    = out_q.op_dec;
  assign io.rd_out    = out_q.rd;
  assign io.out_valid = out_valid_q;
endmodule
